rv_mc_datapath: RTL and testbench
=================================

// Module: rv_mc_datapath
// PURPOSE
//   Multi-cycle RV32I datapath: successor of the single-cycle datapath. Replaces split
//   instr/data ports with one shared memory port using a req/ready handshake.
//   Sequences FETCH/DECODE/EXEC/MEM/WB internally; decode of control stays in the
//   external combinational decoder driven from instr. Adds a parametrised reset vector,
//   byte-lane store strobes and misaligned-access detection.
// PARAMETERS
//   ADDR_W    32         memory address / PC width (16..32); PC wraps mod 2^ADDR_W
//   RESET_PC  'h0        PC value after reset
// PORTS
//   clk         in   1       clock, rising edge
//   rst_n       in   1       async active-low reset
//   instr       out  32      instruction register (IR), to decoder
//   RegWrite    in   1       decoder: write rd in WB
//   ImmSrc      in   3       decoder: immediate format
//   ALUSrcA     in   1       0=rs1, 1=PC
//   ALUSrcB     in   1       0=rs2, 1=imm
//   ALUControl  in   4       ALU operation
//   ResultSrc   in   2       0=ALUOut 1=load data 2=PC+4 3=imm
//   PCSrc       in   2       0=PC+4 1=PC+imm 2={ALUOut[31:1],0}
//   LoadExtSrc  in   3       load size/sign select
//   MemRead     in   1       instruction is a load
//   MemWrite    in   1       instruction is a store
//   Zero/NEG/NEGU out 1 each flags registered at end of EXEC, to decoder
//   PC          out  ADDR_W  current instruction address
//   mem_req     out  1       memory request
//   mem_we      out  1       1=write
//   mem_addr    out  ADDR_W  byte address
//   mem_wdata   out  32      store data, lane-shifted
//   mem_wstrb   out  4       byte enables (0 on reads)
//   mem_rdata   in   32      read data, valid with mem_ready
//   mem_ready   in   1       completes request in this cycle
//   retire      out  1       1-cycle pulse in WB
//   misalign    out  1       1-cycle pulse in WB of a misaligned load/store
// BEHAVIOUR
//   Reset (async): state=FETCH, PC=RESET_PC, IR=0x00000013, flags=0, mem_req/mem_we=0,
//     mem_wstrb=0, retire=misalign=0. First fetch request in first cycle after release.
//   FETCH: mem_req=1, we=0, addr=PC; hold until mem_ready; then IR<=mem_rdata -> DECODE.
//   DECODE: A<=rs1, B<=rs2, imm captured from IR -> EXEC.
//   EXEC: ALUOut<=ALU(SrcA,SrcB); flags registered. Next: MEM if MemRead|MemWrite and
//     aligned; WB otherwise (misaligned sets sticky mis bit, no memory access).
//   MEM: mem_req=1, addr=ALUOut, we=MemWrite; addr/wdata/wstrb/we held stable while
//     mem_ready=0. Load: MDR<=mem_rdata on ready. Then -> WB.
//   WB: rd<=Result if RegWrite and no mis (x0 never written); PC<=PCNext per PCSrc
//     (misaligned forces PC+4); retire=1; misalign=mis -> FETCH.
//   Latency: non-memory instr 4 cycles with zero-wait memory; load/store 5; each
//     memory wait state adds 1.
//   Size = IR[13:12]: 0 byte, 1 half, 2 word. Aligned: half addr[0]=0, word addr[1:0]=0.
//   Store lanes: SB wstrb=1<<a[1:0], SH 3<<a[1:0], SW 0xF; wdata = rs2 replicated.
//   Load data: MDR through load_extender with offset=ALUOut[1:0], LoadExtSrc.
//   mem_ready while mem_req=0 ignored. PC+4 / PC+imm wrap mod 2^ADDR_W.
//   Reset mid-transaction aborts: mem_req drops asynchronously, no reg/PC update.
// TESTING
//   Reset, RESET_PC=0x100, ready=1: first mem_addr=0x100, ADDI x1,x0,5 retires 4 cycles on, x1=5.
//   Fetch with ready low 3 cycles: mem_req/addr stable; IR loads on 4th cycle; retire at cycle 7.
//   SB x2=0xA5 to 0x203: wstrb=4'b1000, wdata=0xA5A5A5A5; LBU back -> rd=0x000000A5.
//   LW at 0x202: no MEM request, misalign=1 in WB, rd unchanged, PC advances +4.
//   BEQ taken imm=-8 at PC=0x20: Zero=1, PCSrc=1 -> PC=0x18; JALR rs1=0x41 -> PC=0x40, rd=PC+4.
//   rst_n low during MEM of a store with ready low: mem_req drops at once, memory untouched, PC=RESET_PC.

Source files
------------

// File: rtl/rv_mc_datapath.sv
// rv_mc_datapath: multi-cycle RV32I datapath sharing one req/ready memory port
// ImmSrc: 0=I 1=S 2=B 3=J 4=U
// ALUControl: 0 add 1 sub 2 and 3 or 4 xor 5 slt 6 sltu 7 sll 8 srl 9 sra, others pass SrcB
// LoadExtSrc: 0 lb 1 lh 4 lbu 5 lhu, others word
module rv_mc_datapath #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       instr,
    input  logic              RegWrite,
    input  logic [2:0]        ImmSrc,
    input  logic              ALUSrcA,
    input  logic              ALUSrcB,
    input  logic [3:0]        ALUControl,
    input  logic [1:0]        ResultSrc,
    input  logic [1:0]        PCSrc,
    input  logic [2:0]        LoadExtSrc,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic              Zero,
    output logic              NEG,
    output logic              NEGU,
    output logic [ADDR_W-1:0] PC,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              misalign
);
    localparam logic [ADDR_W-1:0] PC0 = RESET_PC[ADDR_W-1:0];

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    state_t            state;
    logic [31:0]       rf [32];
    logic [31:0]       a_r, b_r, imm_r, alu_out, mdr;
    logic              mis;
    logic [31:0]       rd1, rd2, imm, src_a, src_b, alu_y, ld_sh, ld_val, result;
    logic [4:0]        rs1, rs2, rd;
    logic [1:0]        size, ea;
    logic              lt_s, lt_u, aligned, is_mem;
    logic [3:0]        wstrb_n;
    logic [31:0]       wdata_n;
    logic [ADDR_W-1:0] pc4, pc_imm, pc_jr, pc_next;

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];
    assign rd1 = rs1 == 5'd0 ? 32'h0 : rf[rs1];
    assign rd2 = rs2 == 5'd0 ? 32'h0 : rf[rs2];

    assign imm = ImmSrc == 3'd1 ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                 ImmSrc == 3'd2 ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                 ImmSrc == 3'd3 ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                 ImmSrc == 3'd4 ? {instr[31:12], 12'h0} :
                                  {{20{instr[31]}}, instr[31:20]};

    assign src_a = ALUSrcA ? 32'(PC) : a_r;
    assign src_b = ALUSrcB ? imm_r : b_r;
    assign lt_s  = $signed(src_a) < $signed(src_b);
    assign lt_u  = src_a < src_b;

    // ALU operation select
    always_comb begin
        case (ALUControl)
            4'd0:    alu_y = src_a + src_b;
            4'd1:    alu_y = src_a - src_b;
            4'd2:    alu_y = src_a & src_b;
            4'd3:    alu_y = src_a | src_b;
            4'd4:    alu_y = src_a ^ src_b;
            4'd5:    alu_y = {31'h0, lt_s};
            4'd6:    alu_y = {31'h0, lt_u};
            4'd7:    alu_y = src_a << src_b[4:0];
            4'd8:    alu_y = src_a >> src_b[4:0];
            4'd9:    alu_y = $signed(src_a) >>> src_b[4:0];
            default: alu_y = src_b;
        endcase
    end

    // Access size lives in funct3; alignment is judged on the fresh ALU result in EXEC
    assign size    = instr[13:12];
    assign ea      = alu_y[1:0];
    assign is_mem  = MemRead | MemWrite;
    assign aligned = size == 2'd0 || (size == 2'd1 && !ea[0]) || ea == 2'd0;
    assign wstrb_n = size == 2'd0 ? 4'b0001 << ea : size == 2'd1 ? 4'b0011 << ea : 4'b1111;
    assign wdata_n = size == 2'd0 ? {4{b_r[7:0]}} : size == 2'd1 ? {2{b_r[15:0]}} : b_r;

    assign ld_sh  = mdr >> {alu_out[1:0], 3'b000};
    assign ld_val = LoadExtSrc == 3'd0 ? {{24{ld_sh[7]}}, ld_sh[7:0]} :
                    LoadExtSrc == 3'd1 ? {{16{ld_sh[15]}}, ld_sh[15:0]} :
                    LoadExtSrc == 3'd4 ? {24'h0, ld_sh[7:0]} :
                    LoadExtSrc == 3'd5 ? {16'h0, ld_sh[15:0]} : ld_sh;

    assign pc4     = PC + ADDR_W'(3'd4);
    assign pc_imm  = PC + imm_r[ADDR_W-1:0];
    assign pc_jr   = {alu_out[ADDR_W-1:1], 1'b0};
    assign pc_next = (mis || PCSrc == 2'd0) ? pc4 : PCSrc == 2'd1 ? pc_imm : pc_jr;
    assign result  = ResultSrc == 2'd0 ? alu_out : ResultSrc == 2'd1 ? ld_val :
                     ResultSrc == 2'd2 ? 32'(pc4) : imm_r;

    // Register file write in WB; x0 and misaligned accesses never write
    always_ff @(posedge clk) begin
        if (state == WB && RegWrite && !mis && rd != 5'd0)
            rf[rd] <= result;
    end

    // Control FSM; memory port signals are registered and set up on entry to FETCH/MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            PC        <= PC0;
            instr     <= 32'h0000_0013;
            a_r       <= '0;
            b_r       <= '0;
            imm_r     <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            mis       <= 1'b0;
            Zero      <= 1'b0;
            NEG       <= 1'b0;
            NEGU      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= PC0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            retire    <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            retire   <= 1'b0;
            misalign <= 1'b0;
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= PC;
                    end else if (mem_ready) begin
                        instr   <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    a_r   <= rd1;
                    b_r   <= rd2;
                    imm_r <= imm;
                    state <= EXEC;
                end
                EXEC: begin
                    alu_out <= alu_y;
                    Zero    <= alu_y == 32'h0;
                    NEG     <= lt_s;
                    NEGU    <= lt_u;
                    if (is_mem && aligned) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= alu_y[ADDR_W-1:0];
                        mem_wdata <= wdata_n;
                        mem_wstrb <= MemWrite ? wstrb_n : 4'b0000;
                        state     <= MEM;
                    end else begin
                        mis      <= is_mem;
                        misalign <= is_mem;
                        retire   <= 1'b1;
                        state    <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (!mem_we)
                            mdr <= mem_rdata;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        retire    <= 1'b1;
                        state     <= WB;
                    end
                end
                WB: begin
                    PC       <= pc_next;
                    mis      <= 1'b0;
                    mem_req  <= 1'b1;
                    mem_addr <= pc_next;
                    state    <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_mc_datapath.sv
// tb_rv_mc_datapath: directed program run against a wait-state memory model and a small decoder
module tb_rv_mc_datapath;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        RegWrite, ALUSrcA, ALUSrcB, MemRead, MemWrite;
    logic [2:0]  ImmSrc, LoadExtSrc;
    logic [3:0]  ALUControl;
    logic [1:0]  ResultSrc, PCSrc;
    logic        Zero, NEG, NEGU;
    logic [31:0] PC;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        retire, misalign;

    logic [31:0] mem [1024];
    int          wait_cycles = 0;
    int          wcnt = 0;
    int          data_hs = 0;
    logic [31:0] w_addr = '0, w_data = '0;
    logic [3:0]  w_strb = '0;
    int          tests = 0;
    int          fails = 0;

    rv_mc_datapath #(.ADDR_W(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .PCSrc(PCSrc), .LoadExtSrc(LoadExtSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .Zero(Zero), .NEG(NEG), .NEGU(NEGU), .PC(PC), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .retire(retire), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Decoder for the handful of instructions the program uses
    always_comb begin
        RegWrite = 1'b0; ImmSrc = 3'd0; ALUSrcA = 1'b0; ALUSrcB = 1'b0; ALUControl = 4'd0;
        ResultSrc = 2'd0; PCSrc = 2'd0; LoadExtSrc = instr[14:12]; MemRead = 1'b0; MemWrite = 1'b0;
        case (instr[6:0])
            7'b0010011: begin RegWrite = 1'b1; ALUSrcB = 1'b1; end
            7'b0000011: begin RegWrite = 1'b1; ALUSrcB = 1'b1; ResultSrc = 2'd1; MemRead = 1'b1; end
            7'b0100011: begin ImmSrc = 3'd1; ALUSrcB = 1'b1; MemWrite = 1'b1; end
            7'b1100011: begin ImmSrc = 3'd2; ALUControl = 4'd1; PCSrc = Zero ? 2'd1 : 2'd0; end
            7'b1100111: begin RegWrite = 1'b1; ALUSrcB = 1'b1; ResultSrc = 2'd2; PCSrc = 2'd2; end
            default: ;
        endcase
    end

    // Memory: ready after wait_cycles request cycles, byte-strobed writes
    assign mem_ready = mem_req && (wcnt >= wait_cycles);
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
        if (mem_req && mem_ready && mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_wstrb[i]) mem[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    // Log data-side handshakes (fetches always present addr == PC)
    always @(negedge clk) begin
        if (mem_req && mem_ready && mem_addr != PC) begin
            data_hs <= data_hs + 1;
            if (mem_we) begin
                w_addr <= mem_addr;
                w_data <= mem_wdata;
                w_strb <= mem_wstrb;
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[11:2]] <= word;
    endtask

    task automatic load_program();
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h0000_0013;
        put(32'h100, enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011));
        put(32'h104, enc_i(12'h0A5, 5'd0, 3'd0, 5'd2, 7'b0010011));
        put(32'h108, enc_i(12'h203, 5'd0, 3'd0, 5'd3, 7'b0010011));
        put(32'h10C, enc_s(12'd0, 5'd2, 5'd3, 3'd0));
        put(32'h110, enc_i(12'd0, 5'd3, 3'd4, 5'd4, 7'b0000011));
        put(32'h114, enc_i(12'h202, 5'd0, 3'd0, 5'd5, 7'b0010011));
        put(32'h118, enc_i(12'd0, 5'd5, 3'd2, 5'd4, 7'b0000011));
        put(32'h11C, enc_i(12'h041, 5'd0, 3'd0, 5'd6, 7'b0010011));
        put(32'h120, enc_i(12'd0, 5'd6, 3'd0, 5'd7, 7'b1100111));
        put(32'h040, enc_i(12'h020, 5'd0, 3'd0, 5'd9, 7'b0010011));
        put(32'h044, enc_i(12'd0, 5'd9, 3'd0, 5'd0, 7'b1100111));
        put(32'h020, enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0));
        put(32'h018, enc_i(12'h300, 5'd0, 3'd0, 5'd10, 7'b0010011));
        put(32'h01C, enc_s(12'd0, 5'd2, 5'd10, 3'd2));
        put(32'h200, 32'h1122_3344);
        put(32'h300, 32'hDEAD_BEEF);
    endtask

    // Run from the current negedge until retire; n = cycles to the WB cycle, ends on next FETCH cycle
    task automatic exec_one(output int n, output logic m);
        n = 0;
        m = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!retire && n < 40);
        m = misalign;
        tests++; if (retire !== 1'b1) begin fails++; $display("FAIL retire timeout: no retire after %0d cycles at PC %h", n, PC); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int   n;
        logic m;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
        tests++; if (instr !== 32'h0000_0013) begin fails++; $display("FAIL reset instr: got %h want 00000013", instr); end
        tests++; if (PC !== 32'h100) begin fails++; $display("FAIL reset PC: got %h want 00000100", PC); end
        tests++; if (retire !== 1'b0 || misalign !== 1'b0) begin fails++; $display("FAIL reset pulses: got %b%b want 00", retire, misalign); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin fails++; $display("FAIL first fetch: got req %b addr %h want 1 00000100", mem_req, mem_addr); end
        exec_one(n, m);
        tests++; if (n !== 3) begin fails++; $display("FAIL addi latency: got %0d want 3", n); end
        tests++; if (dut.rf[1] !== 32'd5) begin fails++; $display("FAIL addi x1: got %h want 00000005", dut.rf[1]); end
    endtask

    task automatic test_fetch_wait();
        int   n;
        logic m;
        wait_cycles = 3;
        for (int i = 0; i < 3; i++) begin
            tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || instr !== 32'h0050_0093) begin fails++; $display("FAIL fetch hold %0d: got req %b addr %h ir %h want 1 00000104 00500093", i, mem_req, mem_addr, instr); end
            @(negedge clk);
        end
        wait_cycles = 0;
        exec_one(n, m);
        tests++; if (n + 3 !== 6) begin fails++; $display("FAIL fetch wait retire: got cycle %0d want 7", n + 4); end
        tests++; if (dut.rf[2] !== 32'hA5) begin fails++; $display("FAIL addi x2: got %h want 000000a5", dut.rf[2]); end
    endtask

    task automatic test_store_load_byte();
        int   n;
        logic m;
        exec_one(n, m);
        exec_one(n, m);
        tests++; if (n !== 4) begin fails++; $display("FAIL sb latency: got %0d want 4", n); end
        tests++; if (m !== 1'b0) begin fails++; $display("FAIL sb misalign: got %b want 0", m); end
        tests++; if (w_addr !== 32'h203) begin fails++; $display("FAIL sb addr: got %h want 00000203", w_addr); end
        tests++; if (w_strb !== 4'b1000) begin fails++; $display("FAIL sb wstrb: got %b want 1000", w_strb); end
        tests++; if (w_data !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb wdata: got %h want a5a5a5a5", w_data); end
        tests++; if (mem[32'h80] !== 32'hA522_3344) begin fails++; $display("FAIL sb memory: got %h want a5223344", mem[32'h80]); end
        exec_one(n, m);
        tests++; if (n !== 4) begin fails++; $display("FAIL lbu latency: got %0d want 4", n); end
        tests++; if (dut.rf[4] !== 32'h0000_00A5) begin fails++; $display("FAIL lbu x4: got %h want 000000a5", dut.rf[4]); end
    endtask

    task automatic test_misalign();
        int   n, d0;
        logic m;
        exec_one(n, m);
        d0 = data_hs;
        exec_one(n, m);
        tests++; if (n !== 3) begin fails++; $display("FAIL lw mis latency: got %0d want 3", n); end
        tests++; if (m !== 1'b1) begin fails++; $display("FAIL lw misalign: got %b want 1", m); end
        tests++; if (data_hs !== d0) begin fails++; $display("FAIL lw mis access: got %0d data requests want 0", data_hs - d0); end
        tests++; if (dut.rf[4] !== 32'h0000_00A5) begin fails++; $display("FAIL lw mis rd: got %h want 000000a5", dut.rf[4]); end
        tests++; if (PC !== 32'h11C || mem_addr !== 32'h11C) begin fails++; $display("FAIL lw mis pc: got %h addr %h want 0000011c", PC, mem_addr); end
    endtask

    task automatic test_jumps();
        int   n;
        logic m;
        exec_one(n, m);
        exec_one(n, m);
        tests++; if (PC !== 32'h40) begin fails++; $display("FAIL jalr pc: got %h want 00000040", PC); end
        tests++; if (dut.rf[7] !== 32'h124) begin fails++; $display("FAIL jalr rd: got %h want 00000124", dut.rf[7]); end
        exec_one(n, m);
        exec_one(n, m);
        tests++; if (PC !== 32'h20) begin fails++; $display("FAIL jalr x0 pc: got %h want 00000020", PC); end
        exec_one(n, m);
        tests++; if (Zero !== 1'b1 || NEG !== 1'b0 || NEGU !== 1'b0) begin fails++; $display("FAIL beq flags: got %b%b%b want 100", Zero, NEG, NEGU); end
        tests++; if (PC !== 32'h18) begin fails++; $display("FAIL beq target: got %h want 00000018", PC); end
    endtask

    task automatic test_reset_abort();
        int   n;
        logic m;
        exec_one(n, m);
        @(negedge clk);
        wait_cycles = 50;
        repeat (2) @(negedge clk);
        tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h300) begin fails++; $display("FAIL sw mem req: got %b%b %h want 11 00000300", mem_req, mem_we, mem_addr); end
        tests++; if (mem_wstrb !== 4'hF || mem_wdata !== 32'hA5) begin fails++; $display("FAIL sw lanes: got %b %h want 1111 000000a5", mem_wstrb, mem_wdata); end
        @(negedge clk);
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_wstrb !== 4'hF) begin fails++; $display("FAIL sw hold: got %b %h %b want 1 00000300 1111", mem_req, mem_addr, mem_wstrb); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL async abort req: got %b want 0", mem_req); end
        tests++; if (PC !== 32'h100) begin fails++; $display("FAIL abort pc: got %h want 00000100", PC); end
        @(negedge clk);
        tests++; if (mem[32'hC0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL abort memory: got %h want deadbeef", mem[32'hC0]); end
        wait_cycles = 0;
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin fails++; $display("FAIL refetch: got %b %h want 1 00000100", mem_req, mem_addr); end
        exec_one(n, m);
        tests++; if (n !== 3 || instr !== 32'h0050_0093) begin fails++; $display("FAIL rerun: got %0d %h want 3 00500093", n, instr); end
    endtask

    initial begin
        rst_n = 1'b0;
        load_program();
        test_reset();
        test_fetch_wait();
        test_store_load_byte();
        test_misalign();
        test_jumps();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
